warp_issue_sched: RTL and testbench
===================================

WARP_ISSUE_SCHED -- requirements
Module: warp_issue_sched

Interface
REQ-001 SHALL have parameter NUM_WARP, default 8: number of warps, ≥2, power of two; WARP_LOG = log2(NUM_WARP).
REQ-002 SHALL have parameter IBUF_DEPTH, default 2: entries per warp buffer, 1..8, any integer.
REQ-003 SHALL have parameter PKT_W, default 64: decoded packet width.
REQ-004 Clock and reset:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
REQ-005 Decode, flush and control inputs:
- stall_i  in  1  blocks issue.
- decValid_i  in  1  decoded packet write.
- decWarp_i  in  WARP_LOG  target warp.
- decPacket_i  in  PKT_W  packet.
- warpEn_i  in  NUM_WARP  warp enable mask.
- warpReady_i  in  NUM_WARP  scoreboard: head packet hazard-free.
- flush_i  in  1  flush one warp.
- flushWarp_i  in  WARP_LOG  warp to flush.
- mode_i  in  1  0 = LRR, 1 = GTO.
REQ-006 Outputs:
- ibufFull_o  out  NUM_WARP  count == IBUF_DEPTH, combinational from state.
- warpValid_o  out  NUM_WARP  count != 0, combinational from state.
- issueValid_o  out  1  registered.
- issueWarp_o  out  WARP_LOG  registered.
- issuePacket_o  out  PKT_W  registered.
- overflow_o  out  1  sticky write-to-full error.

Function
REQ-007 Per warp: circular FIFO of IBUF_DEPTH packets; read/write pointers wrap from IBUF_DEPTH-1 to 0; count width ceil(log2(IBUF_DEPTH+1)).
REQ-008 Write rule: decValid_i with count < IBUF_DEPTH SHALL append decPacket_i at the edge; the new entry is not eligible until the next cycle.
REQ-009 Write to a full warp SHALL be dropped and SHALL set overflow_o, cleared only by reset; a same-cycle pop does not make room.
REQ-010 Warp w is eligible when all hold:
- warpEn_i[w]
- count[w] > 0
- warpReady_i[w]
- !(flush_i && flushWarp_i == w)
REQ-011 LRR mode: select the first eligible warp scanning from lastIssued+1 modulo NUM_WARP.
REQ-012 GTO mode: select lastIssued if eligible; otherwise the lowest-index eligible warp.
REQ-013 Issue with stall_i=0 and any eligible warp: at the edge, register issueValid_o=1, issueWarp_o=selected warp, issuePacket_o=head packet; pop that head; update lastIssued. Latency is one cycle from eligibility to output.
REQ-014 stall_i=1 or no eligible warp: issueValid_o=0 next cycle; issueWarp_o and issuePacket_o hold; no pop; lastIssued holds; writes still proceed.
REQ-015 Flush: flush_i SHALL zero count and both pointers of flushWarp_i at the edge.
REQ-016 Flush and decode write to the same warp in the same cycle: flush wins and the write is dropped (no overflow).
REQ-017 Flush and write to different warps in the same cycle: both take effect.
REQ-018 Simultaneous write and pop on the same non-full warp: count unchanged, both pointers advance.
REQ-019 At most one issue per cycle.

Reset
REQ-020 Reset SHALL clear all of:
- counts and pointers.
- issueValid_o, issueWarp_o, issuePacket_o to 0.
- overflow_o to 0.
- lastIssued to NUM_WARP-1, so warp 0 wins first under LRR.
REQ-021 Reset asserted mid-operation SHALL discard all buffered packets immediately; first issue is possible two edges after reset deassert plus a write.

Configuration
REQ-022 Macro ISSUE_SCHED_GTO_EN defined: mode_i selects LRR/GTO per REQ-011/012.
REQ-023 Macro undefined: GTO logic is absent, mode_i is ignored, and selection is LRR only.

Verification
REQ-024 Write warp0 P0, warp3 P3 with all ready, mode=LRR -> issue warp0/P0 then warp3/P3 on consecutive cycles, then issueValid_o=0.
REQ-025 IBUF_DEPTH=2, three writes to warp 5 with warpReady_i=0 -> ibufFull_o[5]=1 after the second write; third write dropped; overflow_o=1; then ready -> exactly two issues.
REQ-026 GTO (macro defined), warps 1 and 2 each hold two packets, all ready -> issue order 1,1,2,2; same stimulus in LRR -> 1,2,1,2.
REQ-027 Warp 4 holds packets; flush_i=1 with flushWarp_i=4 while warp 4 is eligible and a write targets warp 4 -> no issue of warp 4; warpValid_o[4]=0 next cycle; overflow_o=0.
REQ-028 stall_i=1 for 3 cycles with eligible warps -> issueValid_o=0 throughout and counts unchanged; release -> issue resumes from lastIssued+1.
REQ-029 Assert reset with 4 packets buffered -> all outputs 0 and warpValid_o=0 at once; after deassert, a write to warp 7 -> issue warp 7.

Source files
------------

// File: rtl/warp_issue_sched.sv
// Per-warp instruction buffers feeding a one-per-cycle issue stage (LRR, optional GTO); issue output registered, 1-cycle latency.
// stall_i holds issue without blocking decode writes; define ISSUE_SCHED_GTO_EN to build GTO selection under mode_i.
module warp_issue_sched #(
    parameter int NUM_WARP   = 8,
    parameter int IBUF_DEPTH = 2,
    parameter int PKT_W      = 64,
    localparam int WARP_LOG  = $clog2(NUM_WARP)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_i,
    input  logic                decValid_i,
    input  logic [WARP_LOG-1:0] decWarp_i,
    input  logic [PKT_W-1:0]    decPacket_i,
    input  logic [NUM_WARP-1:0] warpEn_i,
    input  logic [NUM_WARP-1:0] warpReady_i,
    input  logic                flush_i,
    input  logic [WARP_LOG-1:0] flushWarp_i,
    input  logic                mode_i,
    output logic [NUM_WARP-1:0] ibufFull_o,
    output logic [NUM_WARP-1:0] warpValid_o,
    output logic                issueValid_o,
    output logic [WARP_LOG-1:0] issueWarp_o,
    output logic [PKT_W-1:0]    issuePacket_o,
    output logic                overflow_o
);

    localparam int PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(IBUF_DEPTH + 1);

    logic [PKT_W-1:0]                mem_q [NUM_WARP][IBUF_DEPTH];
    logic [NUM_WARP-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_WARP-1:0][PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [NUM_WARP-1:0][PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [WARP_LOG-1:0]             last_q;
    logic                            issue_valid_q;
    logic [WARP_LOG-1:0]             issue_warp_q;
    logic [PKT_W-1:0]                issue_pkt_q;
    logic                            ovf_q;

    logic [NUM_WARP-1:0] full_w, nonempty_w, flush_w, elig, push_w, pop_w;
    logic [WARP_LOG-1:0] lrr_sel, sel;
    logic                issue_go, dec_full, dec_flushed, wr_en, ovf_set;
    logic [PKT_W-1:0]    head_pkt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(IBUF_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    function automatic logic [WARP_LOG-1:0] warp_add(input logic [WARP_LOG-1:0] a,
                                                    input int unsigned b);
        return a + WARP_LOG'(b);
    endfunction

    always_comb begin
        full_w     = '0;
        nonempty_w = '0;
        flush_w    = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            full_w[w]     = (cnt_q[w] == CNT_W'(IBUF_DEPTH));
            nonempty_w[w] = (cnt_q[w] != '0);
        end
        if (flush_i) flush_w[flushWarp_i] = 1'b1;
    end

    // A warp being flushed this cycle must not issue its doomed head packet.
    assign elig     = warpEn_i & warpReady_i & nonempty_w & ~flush_w;
    assign issue_go = !stall_i && (|elig);

    // Lowest offset from last_q+1 wins; offset NUM_WARP wraps back to last_q itself.
    always_comb begin
        lrr_sel = last_q;
        for (int i = NUM_WARP; i >= 1; i--) begin
            if (elig[warp_add(last_q, i)]) lrr_sel = warp_add(last_q, i);
        end
    end

`ifdef ISSUE_SCHED_GTO_EN
    logic [WARP_LOG-1:0] gto_sel;

    always_comb begin
        gto_sel = last_q;
        if (!elig[last_q]) begin
            for (int w = NUM_WARP - 1; w >= 0; w--) begin
                if (elig[w]) gto_sel = WARP_LOG'(w);
            end
        end
    end

    assign sel = mode_i ? gto_sel : lrr_sel;
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign sel         = lrr_sel;
`endif

    assign head_pkt = mem_q[sel][rd_ptr_q[sel]];

    // Fullness is judged on the pre-pop count; a flush of the same warp silently drops the write.
    assign dec_full    = full_w[decWarp_i];
    assign dec_flushed = flush_i && (flushWarp_i == decWarp_i);
    assign wr_en       = decValid_i && !dec_full && !dec_flushed;
    assign ovf_set     = decValid_i && dec_full && !dec_flushed;

    always_comb begin
        push_w = '0;
        pop_w  = '0;
        if (wr_en)    push_w[decWarp_i] = 1'b1;
        if (issue_go) pop_w[sel]        = 1'b1;
    end

    always_comb begin
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        for (int w = 0; w < NUM_WARP; w++) begin
            if (flush_w[w]) begin
                cnt_d[w]    = '0;
                rd_ptr_d[w] = '0;
                wr_ptr_d[w] = '0;
            end else begin
                if (push_w[w]) wr_ptr_d[w] = ptr_inc(wr_ptr_q[w]);
                if (pop_w[w])  rd_ptr_d[w] = ptr_inc(rd_ptr_q[w]);
                if (push_w[w] && !pop_w[w])
                    cnt_d[w] = cnt_q[w] + CNT_W'(1);
                else if (!push_w[w] && pop_w[w])
                    cnt_d[w] = cnt_q[w] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[decWarp_i][wr_ptr_q[decWarp_i]] <= decPacket_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            last_q        <= WARP_LOG'(NUM_WARP - 1);
            issue_valid_q <= 1'b0;
            issue_warp_q  <= '0;
            issue_pkt_q   <= '0;
            ovf_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            issue_valid_q <= issue_go;
            if (issue_go) begin
                issue_warp_q <= sel;
                issue_pkt_q  <= head_pkt;
                last_q       <= sel;
            end
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

    assign ibufFull_o    = full_w;
    assign warpValid_o   = nonempty_w;
    assign issueValid_o  = issue_valid_q;
    assign issueWarp_o   = issue_warp_q;
    assign issuePacket_o = issue_pkt_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_warp_issue_sched.sv
// Bench for warp_issue_sched: directed vector table, reset sequence, then randomized run against a queue-style model.
module tb_warp_issue_sched;
    localparam int NW = 8;
    localparam int D  = 2;
    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall, dec_vld, flush, mode;
    logic [2:0]    dec_warp, flush_warp;
    logic [PW-1:0] dec_pkt;
    logic [NW-1:0] warp_en, warp_rdy;
    logic [NW-1:0] ibuf_full, warp_valid;
    logic          issue_vld, ovf;
    logic [2:0]    issue_warp;
    logic [PW-1:0] issue_pkt;

    int n_checks = 0;
    int n_pass   = 0;

    warp_issue_sched #(.NUM_WARP(NW), .IBUF_DEPTH(D), .PKT_W(PW)) dut (
        .clk(clk), .reset(reset), .stall_i(stall), .decValid_i(dec_vld),
        .decWarp_i(dec_warp), .decPacket_i(dec_pkt), .warpEn_i(warp_en),
        .warpReady_i(warp_rdy), .flush_i(flush), .flushWarp_i(flush_warp),
        .mode_i(mode), .ibufFull_o(ibuf_full), .warpValid_o(warp_valid),
        .issueValid_o(issue_vld), .issueWarp_o(issue_warp),
        .issuePacket_o(issue_pkt), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        bit            dv;
        int            dw;
        logic [63:0]   pk;
        logic [7:0]    rdy;
        bit            st;
        bit            fl;
        int            fw;
        bit            e_v;
        int            e_w;
        logic [63:0]   e_p;
        logic [7:0]    e_full;
        logic [7:0]    e_wv;
        bit            e_ovf;
    } vec_t;

    function automatic vec_t mk(bit dv, int dw, logic [63:0] pk, logic [7:0] rdy, bit st,
                                bit fl, int fw, bit e_v, int e_w, logic [63:0] e_p,
                                logic [7:0] e_full, logic [7:0] e_wv, bit e_ovf);
        vec_t v;
        v.dv = dv; v.dw = dw; v.pk = pk; v.rdy = rdy; v.st = st; v.fl = fl; v.fw = fw;
        v.e_v = e_v; v.e_w = e_w; v.e_p = e_p; v.e_full = e_full; v.e_wv = e_wv; v.e_ovf = e_ovf;
        return v;
    endfunction

    // Reference model: each warp buffer is an ordered list with the head at index 0.
    logic [63:0] m_buf [NW][D];
    int          m_cnt [NW];
    int          m_last;
    bit          m_ovf, m_valid;
    int          m_warp;
    logic [63:0] m_pkt;
    bit          gto_built;

    task automatic model_reset();
        for (int w = 0; w < NW; w++) m_cnt[w] = 0;
        m_last = NW - 1; m_ovf = 0; m_valid = 0; m_warp = 0; m_pkt = '0;
    endtask

    task automatic model_step();
        bit elig [NW];
        bit any;
        int sel;
        bit full_pre, wflush;
        any = 0;
        sel = -1;
        for (int w = 0; w < NW; w++) begin
            elig[w] = warp_en[w] && (m_cnt[w] > 0) && warp_rdy[w] && !(flush && flush_warp == w);
            any |= elig[w];
        end
        if (gto_built && mode) begin
            if (elig[m_last]) sel = m_last;
            else for (int w = 0; w < NW; w++) if (sel < 0 && elig[w]) sel = w;
        end else begin
            for (int k = 1; k <= NW; k++)
                if (sel < 0 && elig[(m_last + k) % NW]) sel = (m_last + k) % NW;
        end
        full_pre = (m_cnt[dec_warp] == D);
        wflush   = flush && (flush_warp == dec_warp);
        m_valid  = !stall && any;
        if (m_valid) begin
            m_warp = sel;
            m_pkt  = m_buf[sel][0];
            for (int k = 0; k < D - 1; k++) m_buf[sel][k] = m_buf[sel][k + 1];
            m_cnt[sel]--;
            m_last = sel;
        end
        if (dec_vld && !wflush) begin
            if (full_pre) m_ovf = 1;
            else begin
                m_buf[dec_warp][m_cnt[dec_warp]] = dec_pkt;
                m_cnt[dec_warp]++;
            end
        end
        if (flush) m_cnt[flush_warp] = 0;
    endtask

    task automatic idle_inputs();
        stall = 0; dec_vld = 0; dec_warp = 0; dec_pkt = '0; flush = 0; flush_warp = 0;
        warp_en = '1; warp_rdy = '1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        @(negedge clk);
        reset = 0;
    endtask

    vec_t tbl [24];

    initial begin
`ifdef ISSUE_SCHED_GTO_EN
        gto_built = 1;
`else
        gto_built = 0;
`endif
        //            dv dw pk     rdy  st fl fw  v  w  pkt    full  wv    ovf
        tbl[0]  = mk(1, 0, 'hA0, 'hFF, 0, 0, 0, 0, 0, 'h0,  'h00, 'h01, 0);
        tbl[1]  = mk(1, 3, 'hA3, 'hFF, 0, 0, 0, 1, 0, 'hA0, 'h00, 'h08, 0);
        tbl[2]  = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 1, 3, 'hA3, 'h00, 'h00, 0);
        tbl[3]  = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 0, 3, 'hA3, 'h00, 'h00, 0);
        tbl[4]  = mk(1, 4, 'hC0, 'h00, 0, 0, 0, 0, 3, 'hA3, 'h00, 'h10, 0);
        tbl[5]  = mk(1, 4, 'hC1, 'h00, 0, 0, 0, 0, 3, 'hA3, 'h10, 'h10, 0);
        tbl[6]  = mk(1, 4, 'hC2, 'hFF, 0, 1, 4, 0, 3, 'hA3, 'h00, 'h00, 0);
        tbl[7]  = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 0, 3, 'hA3, 'h00, 'h00, 0);
        tbl[8]  = mk(1, 6, 'hD6, 'hFF, 0, 1, 4, 0, 3, 'hA3, 'h00, 'h40, 0);
        tbl[9]  = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 1, 6, 'hD6, 'h00, 'h00, 0);
        tbl[10] = mk(1, 5, 'hB0, 'h00, 0, 0, 0, 0, 6, 'hD6, 'h00, 'h20, 0);
        tbl[11] = mk(1, 5, 'hB1, 'h00, 0, 0, 0, 0, 6, 'hD6, 'h20, 'h20, 0);
        tbl[12] = mk(1, 5, 'hB2, 'h00, 0, 0, 0, 0, 6, 'hD6, 'h20, 'h20, 1);
        tbl[13] = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 1, 5, 'hB0, 'h00, 'h20, 1);
        tbl[14] = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 1, 5, 'hB1, 'h00, 'h00, 1);
        tbl[15] = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 0, 5, 'hB1, 'h00, 'h00, 1);
        tbl[16] = mk(1, 1, 'hE1, 'hFF, 1, 0, 0, 0, 5, 'hB1, 'h00, 'h02, 1);
        tbl[17] = mk(1, 2, 'hE2, 'hFF, 1, 0, 0, 0, 5, 'hB1, 'h00, 'h06, 1);
        tbl[18] = mk(1, 6, 'hE6, 'hFF, 1, 0, 0, 0, 5, 'hB1, 'h00, 'h46, 1);
        tbl[19] = mk(0, 0, 'h0,  'hFF, 1, 0, 0, 0, 5, 'hB1, 'h00, 'h46, 1);
        tbl[20] = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 1, 6, 'hE6, 'h00, 'h06, 1);
        tbl[21] = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 1, 1, 'hE1, 'h00, 'h04, 1);
        tbl[22] = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 1, 2, 'hE2, 'h00, 'h00, 1);
        tbl[23] = mk(0, 0, 'h0,  'hFF, 0, 0, 0, 0, 2, 'hE2, 'h00, 'h00, 1);

        reset = 1;
        mode  = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst valid", issue_vld, 0);
        check("rst warp", issue_warp, 0);
        check("rst pkt", issue_pkt, 0);
        check("rst ovf", ovf, 0);
        check("rst wvalid", warp_valid, 0);
        check("rst full", ibuf_full, 0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            dec_vld = tbl[i].dv; dec_warp = 3'(tbl[i].dw); dec_pkt = tbl[i].pk;
            warp_rdy = tbl[i].rdy; stall = tbl[i].st; flush = tbl[i].fl;
            flush_warp = 3'(tbl[i].fw);
            @(posedge clk);
            #1;
            check($sformatf("row%0d valid", i), issue_vld, tbl[i].e_v);
            check($sformatf("row%0d warp", i), issue_warp, tbl[i].e_w);
            check($sformatf("row%0d pkt", i), issue_pkt, tbl[i].e_p);
            check($sformatf("row%0d full", i), ibuf_full, tbl[i].e_full);
            check($sformatf("row%0d wvalid", i), warp_valid, tbl[i].e_wv);
            check($sformatf("row%0d ovf", i), ovf, tbl[i].e_ovf);
        end

        // Mid-operation reset with four buffered packets.
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            idle_inputs();
            warp_rdy = '0; dec_vld = 1; dec_warp = 3'(w); dec_pkt = 64'h100 + 64'(w);
        end
        @(negedge clk);
        idle_inputs();
        warp_rdy = '0;
        #1;
        check("pre-rst wvalid", warp_valid, 8'h0F);
        #2;
        reset = 1;
        #1;
        check("async rst valid", issue_vld, 0);
        check("async rst warp", issue_warp, 0);
        check("async rst pkt", issue_pkt, 0);
        check("async rst ovf", ovf, 0);
        check("async rst wvalid", warp_valid, 0);
        check("async rst full", ibuf_full, 0);
        @(negedge clk);
        reset = 0; warp_rdy = '1; dec_vld = 1; dec_warp = 3'd7; dec_pkt = 64'hF7;
        @(posedge clk);
        #1;
        check("post-rst 1st valid", issue_vld, 0);
        check("post-rst wvalid", warp_valid, 8'h80);
        @(negedge clk);
        dec_vld = 0;
        @(posedge clk);
        #1;
        check("post-rst issue valid", issue_vld, 1);
        check("post-rst issue warp", issue_warp, 7);
        check("post-rst issue pkt", issue_pkt, 64'hF7);

        // Randomized phase against the model, both modes.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            model_reset();
            mode = r[0];
            for (int c = 0; c < 600; c++) begin
                logic [NW-1:0] exp_full, exp_wv;
                @(negedge clk);
                dec_vld    = ($urandom_range(0, 9) < 6);
                dec_warp   = 3'($urandom_range(0, NW - 1));
                dec_pkt    = {$urandom, $urandom};
                warp_en    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : '1;
                warp_rdy   = 8'($urandom) | 8'($urandom);
                stall      = ($urandom_range(0, 4) == 0);
                flush      = ($urandom_range(0, 9) == 0);
                flush_warp = 3'($urandom_range(0, NW - 1));
                model_step();
                @(posedge clk);
                #1;
                for (int w = 0; w < NW; w++) begin
                    exp_full[w] = (m_cnt[w] == D);
                    exp_wv[w]   = (m_cnt[w] != 0);
                end
                check($sformatf("rnd%0d.%0d valid", r, c), issue_vld, m_valid);
                check($sformatf("rnd%0d.%0d warp", r, c), issue_warp, m_warp);
                check($sformatf("rnd%0d.%0d pkt", r, c), issue_pkt, m_pkt);
                check($sformatf("rnd%0d.%0d ovf", r, c), ovf, m_ovf);
                check($sformatf("rnd%0d.%0d full", r, c), ibuf_full, exp_full);
                check($sformatf("rnd%0d.%0d wvalid", r, c), warp_valid, exp_wv);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
